// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter with a one-word holding register, optional even/odd parity and one or two stop bits.
// Line, busy and done are registered; tx_ready is combinational from reset, enable and holding-register state.
module uart_tx_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_enable,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    output logic                  tx_data_out,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state;
    logic [CW-1:0]         baud;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] sh, hold_data, ld_data;
    logic [1:0]            hold_pm, ld_pm;
    logic                  hold_full, hold_ts, ld_ts, fr_ts, fr_par_en, fr_par;
    logic                  accept, bit_end, last_stop, frame_end, shift_free, load_hold, load_in;
    // The shift stage counts as free in the last cycle of a frame so the next word starts with no idle gap.
    always_comb begin
        tx_ready   = tx_enable && !hold_full && !rst;
        accept     = tx_valid && tx_ready;
        bit_end    = baud == CW'(CLKS_PER_BIT - 1);
        last_stop  = state == STOP && bit_cnt == BW'(fr_ts);
        frame_end  = last_stop && bit_end;
        shift_free = state == IDLE || frame_end;
        load_hold  = shift_free && tx_enable && hold_full;
        load_in    = shift_free && accept;
        ld_data    = load_hold ? hold_data : tx_data_in;
        ld_pm      = load_hold ? hold_pm : parity_mode;
        ld_ts      = load_hold ? hold_ts : two_stop;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baud        <= '0;
            bit_cnt     <= '0;
            hold_full   <= 1'b0;
            tx_data_out <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= last_stop && baud == CW'(CLKS_PER_BIT - 2);
            if (accept && !load_in) begin
                hold_full <= 1'b1;
                hold_data <= tx_data_in;
                hold_pm   <= parity_mode;
                hold_ts   <= two_stop;
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
            if (load_hold || load_in) begin
                state       <= START;
                baud        <= '0;
                bit_cnt     <= '0;
                sh          <= ld_data;
                fr_par_en   <= ld_pm[0] ^ ld_pm[1];
                fr_par      <= ^ld_data ^ ld_pm[1];
                fr_ts       <= ld_ts;
                tx_data_out <= 1'b0;
                busy        <= 1'b1;
            end else if (frame_end) begin
                state       <= IDLE;
                baud        <= '0;
                bit_cnt     <= '0;
                tx_data_out <= 1'b1;
                busy        <= 1'b0;
            end else if (state != IDLE) begin
                baud <= bit_end ? '0 : baud + 1'b1;
                if (bit_end) begin
                    case (state)
                        START: begin
                            state       <= DATA;
                            bit_cnt     <= '0;
                            tx_data_out <= sh[0];
                        end
                        DATA: begin
                            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                                state       <= fr_par_en ? PARITY : STOP;
                                bit_cnt     <= '0;
                                tx_data_out <= fr_par_en ? fr_par : 1'b1;
                            end else begin
                                bit_cnt     <= bit_cnt + 1'b1;
                                sh          <= sh >> 1;
                                tx_data_out <= sh[1];
                            end
                        end
                        PARITY: begin
                            state       <= STOP;
                            bit_cnt     <= '0;
                            tx_data_out <= 1'b1;
                        end
                        STOP: begin
                            bit_cnt     <= bit_cnt + 1'b1;
                            tx_data_out <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule
